// File: rtl/aud_mem_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : aud_mem_scheduler_if
// Desc     : Signal bundle between the audio memory scheduler and its
//            surroundings: keys, recorder, player, SRAM pins and status.
//            Signal names are from the scheduler's point of view.
// Revision : 1.0  initial release
// ============================================================================
interface aud_mem_scheduler_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
);
   logic              i_key_rec;
   logic              i_key_play;
   logic              i_key_pause;
   logic              i_key_stop;
   logic              o_rec_start;
   logic              o_rec_pause;
   logic              o_rec_stop;
   logic              i_rec_valid;
   logic [ADDR_W-1:0] i_rec_addr;
   logic [DATA_W-1:0] i_rec_data;
   logic              o_play_start;
   logic              o_play_pause;
   logic              o_play_stop;
   logic              i_play_req;
   logic [ADDR_W-1:0] i_play_addr;
   logic [DATA_W-1:0] o_play_data;
   logic              o_play_valid;
   logic [ADDR_W-1:0] o_sram_addr;
   logic [DATA_W-1:0] o_sram_wdata;
   logic              o_sram_we_n;
   logic              o_sram_oe_n;
   logic [DATA_W-1:0] i_sram_rdata;
   logic [ADDR_W-1:0] o_end_addr;
   logic [2:0]        o_mode;
   logic              o_overrun;

   // Scheduler side
   modport slave (
      input  i_key_rec, i_key_play, i_key_pause, i_key_stop,
      input  i_rec_valid, i_rec_addr, i_rec_data,
      input  i_play_req, i_play_addr, i_sram_rdata,
      output o_rec_start, o_rec_pause, o_rec_stop,
      output o_play_start, o_play_pause, o_play_stop,
      output o_play_data, o_play_valid,
      output o_sram_addr, o_sram_wdata, o_sram_we_n, o_sram_oe_n,
      output o_end_addr, o_mode, o_overrun
   );

   // Environment side: keys, recorder, player and SRAM device
   modport master (
      output i_key_rec, i_key_play, i_key_pause, i_key_stop,
      output i_rec_valid, i_rec_addr, i_rec_data,
      output i_play_req, i_play_addr, i_sram_rdata,
      input  o_rec_start, o_rec_pause, o_rec_stop,
      input  o_play_start, o_play_pause, o_play_stop,
      input  o_play_data, o_play_valid,
      input  o_sram_addr, o_sram_wdata, o_sram_we_n, o_sram_oe_n,
      input  o_end_addr, o_mode, o_overrun
   );
endinterface
`default_nettype wire

// File: rtl/aud_mem_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : aud_mem_scheduler
// Desc     : Record/playback mode controller and single-port SRAM scheduler.
//            Keys become registered start/pause/stop pulses, recorder words
//            become timed SRAM writes, player fetches become timed reads, and
//            the end of the last recording bounds playback.
// Revision : 1.0  initial release
// ============================================================================
module aud_mem_scheduler #(
   parameter int ADDR_W   = 20,
   parameter int DATA_W   = 16,
   parameter int MAX_ADDR = 1024000,
   parameter int ACC_CYC  = 2
) (
   input  wire logic          i_clk,
   input  wire logic          i_rst_n,   // synchronous, active-high despite the name
   aud_mem_scheduler_if.slave bus
);
   localparam int                 c_cnt_w    = $clog2(ACC_CYC + 1);
   localparam logic [c_cnt_w-1:0] c_acc_load = c_cnt_w'(ACC_CYC);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(1);
   localparam logic [ADDR_W-1:0]  c_max_addr = ADDR_W'(MAX_ADDR);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REC    = 3'd1,
      ST_RPAUSE = 3'd2,
      ST_PLAY   = 3'd3,
      ST_PPAUSE = 3'd4,
      ST_DRAIN  = 3'd5
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_cnt_w-1:0] r_acc_cnt;
   logic               r_we_n;
   logic               r_oe_n;
   logic [ADDR_W-1:0]  r_sram_addr;
   logic [DATA_W-1:0]  r_sram_wdata;
   logic [DATA_W-1:0]  r_play_data;
   logic               r_play_valid;
   logic [ADDR_W-1:0]  r_end_addr;
   logic               r_overrun;
   logic               r_rec_start,  r_rec_pause,  r_rec_stop;
   logic               r_play_start, r_play_pause, r_play_stop;
   logic               w_rec_start,  w_rec_pause,  w_rec_stop;
   logic               w_play_start, w_play_pause, w_play_stop;
   logic               w_clr_rec;
   logic               w_in_rec, w_in_play, w_port_idle;
   logic               w_wr_acc, w_rd_go, w_rd_oob, w_rd_acc, w_drop;
   logic               w_top_pause, w_top_rec, w_top_play;

   // Only the highest-priority key acts: stop > pause > rec > play
   assign w_top_pause = bus.i_key_pause & ~bus.i_key_stop;
   assign w_top_rec   = bus.i_key_rec & ~bus.i_key_pause & ~bus.i_key_stop;
   assign w_top_play  = bus.i_key_play & ~bus.i_key_rec & ~bus.i_key_pause & ~bus.i_key_stop;

   assign w_in_rec    = (r_state == ST_REC)  || (r_state == ST_RPAUSE);
   assign w_in_play   = (r_state == ST_PLAY) || (r_state == ST_PPAUSE);
   assign w_port_idle = (r_acc_cnt == '0);
   assign w_wr_acc    = w_in_rec && bus.i_rec_valid && w_port_idle;
   assign w_rd_go     = w_in_play && bus.i_play_req && w_port_idle;
   assign w_rd_oob    = w_rd_go && (bus.i_play_addr >= r_end_addr);
   assign w_rd_acc    = w_rd_go && !w_rd_oob;
   // A request landing on a busy port is lost, including on the last strobe cycle
   assign w_drop      = ((w_in_rec && bus.i_rec_valid) || (w_in_play && bus.i_play_req))
                        && !w_port_idle;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst_n) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state and control-pulse decode
   always_comb begin
      w_state_nxt  = r_state;
      w_rec_start  = 1'b0;
      w_rec_pause  = 1'b0;
      w_rec_stop   = 1'b0;
      w_play_start = 1'b0;
      w_play_pause = 1'b0;
      w_play_stop  = 1'b0;
      w_clr_rec    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_top_rec) begin
               w_rec_start = 1'b1;
               w_clr_rec   = 1'b1;
               w_state_nxt = ST_REC;
            end else if (w_top_play && (r_end_addr != '0)) begin
               w_play_start = 1'b1;
               w_state_nxt  = ST_PLAY;
            end
         end
         ST_REC: begin
            // Reaching capacity behaves like a stop key
            if (bus.i_key_stop || (r_end_addr == c_max_addr)) begin
               w_rec_stop  = 1'b1;
               w_state_nxt = ST_DRAIN;
            end else if (w_top_pause) begin
               w_rec_pause = 1'b1;
               w_state_nxt = ST_RPAUSE;
            end
         end
         ST_RPAUSE: begin
            if (bus.i_key_stop) begin
               w_rec_stop  = 1'b1;
               w_state_nxt = ST_DRAIN;
            end else if (w_top_pause) begin
               w_rec_pause = 1'b1;
               w_state_nxt = ST_REC;
            end
         end
         ST_PLAY, ST_PPAUSE: begin
            // Keys win over an out-of-range fetch in the same cycle
            if (bus.i_key_stop) begin
               w_play_stop = 1'b1;
               w_state_nxt = ST_DRAIN;
            end else if (w_top_pause) begin
               w_play_pause = 1'b1;
               w_state_nxt  = (r_state == ST_PLAY) ? ST_PPAUSE : ST_PLAY;
            end else if (w_rd_oob) begin
               w_play_stop = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (w_port_idle) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Registered one-cycle control pulses
   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         r_rec_start  <= 1'b0;
         r_rec_pause  <= 1'b0;
         r_rec_stop   <= 1'b0;
         r_play_start <= 1'b0;
         r_play_pause <= 1'b0;
         r_play_stop  <= 1'b0;
      end else begin
         r_rec_start  <= w_rec_start;
         r_rec_pause  <= w_rec_pause;
         r_rec_stop   <= w_rec_stop;
         r_play_start <= w_play_start;
         r_play_pause <= w_play_pause;
         r_play_stop  <= w_play_stop;
      end
   end

   // SRAM port sequencer: strobe held for ACC_CYC cycles, read data captured on the last one
   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         r_acc_cnt    <= '0;
         r_we_n       <= 1'b1;
         r_oe_n       <= 1'b1;
         r_sram_addr  <= '0;
         r_sram_wdata <= '0;
         r_play_data  <= '0;
         r_play_valid <= 1'b0;
      end else begin
         r_play_valid <= 1'b0;
         if (!w_port_idle) begin
            r_acc_cnt <= r_acc_cnt - 1'b1;
            if (r_acc_cnt == c_cnt_last) begin
               r_we_n <= 1'b1;
               r_oe_n <= 1'b1;
               if (!r_oe_n) begin
                  r_play_data  <= bus.i_sram_rdata;
                  r_play_valid <= 1'b1;
               end
            end
         end else if (w_wr_acc) begin
            r_sram_addr  <= bus.i_rec_addr;
            r_sram_wdata <= bus.i_rec_data;
            r_we_n       <= 1'b0;
            r_acc_cnt    <= c_acc_load;
         end else if (w_rd_acc) begin
            r_sram_addr <= bus.i_play_addr;
            r_oe_n      <= 1'b0;
            r_acc_cnt   <= c_acc_load;
         end
      end
   end

   // Recording extent and sticky overrun flag
   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         r_end_addr <= '0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_clr_rec) begin
            r_end_addr <= '0;
            r_overrun  <= 1'b0;
         end else begin
            if (w_wr_acc) r_end_addr <= bus.i_rec_addr + 1'b1;
            if (w_drop)   r_overrun  <= 1'b1;
         end
      end
   end

   assign bus.o_rec_start  = r_rec_start;
   assign bus.o_rec_pause  = r_rec_pause;
   assign bus.o_rec_stop   = r_rec_stop;
   assign bus.o_play_start = r_play_start;
   assign bus.o_play_pause = r_play_pause;
   assign bus.o_play_stop  = r_play_stop;
   assign bus.o_play_data  = r_play_data;
   assign bus.o_play_valid = r_play_valid;
   assign bus.o_sram_addr  = r_sram_addr;
   assign bus.o_sram_wdata = r_sram_wdata;
   assign bus.o_sram_we_n  = r_we_n;
   assign bus.o_sram_oe_n  = r_oe_n;
   assign bus.o_end_addr   = r_end_addr;
   assign bus.o_mode       = r_state;
   assign bus.o_overrun    = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_aud_mem_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_aud_mem_scheduler
// Desc     : Scoreboard bench for aud_mem_scheduler. A cycle-level reference
//            model predicts mode, pulses, strobes and status for every cycle
//            plus the queue of SRAM writes and player read data.
// Revision : 1.0  initial release
// ============================================================================
module tb_aud_mem_scheduler;
   localparam int C_ACC = 2;
   localparam int C_MAX = 8;
   localparam int MI = 0, MR = 1, MRP = 2, MP = 3, MPP = 4, MD = 5;

   typedef struct packed {
      logic [2:0]  mode;
      logic [5:0]  pulses;   // rec_start,rec_pause,rec_stop,play_start,play_pause,play_stop
      logic        valid;
      logic        we_n;
      logic        oe_n;
      logic        ovr;
      logic [19:0] end_a;
      logic        chk_rst;
   } exp_t;
   typedef struct packed {
      logic [19:0] a;
      logic [15:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   aud_mem_scheduler_if #(.ADDR_W(20), .DATA_W(16)) bus ();

   aud_mem_scheduler #(
      .ADDR_W(20), .DATA_W(16), .MAX_ADDR(C_MAX), .ACC_CYC(C_ACC)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst),
      .bus     (bus)
   );

   // SRAM device model, cleared on reset
   logic [15:0] sram [0:1023];
   assign bus.i_sram_rdata = bus.o_sram_oe_n ? 16'hDEAD : sram[bus.o_sram_addr[9:0]];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) sram[i] <= 16'h0000;
      end else if (bus.o_sram_we_n == 1'b0) begin
         sram[bus.o_sram_addr[9:0]] <= bus.o_sram_wdata;
      end
   end

   exp_t        exp_q[$];
   wr_t         wr_q[$];
   logic [15:0] rd_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s @%0t: actual=0x%0h required=0x%0h", nm, $time, act, req);
      end
   endtask

   // Monitor: per-cycle state, write events at we_n fall, read data at play_valid
   logic we_prev = 1'b1;
   always @(negedge clk) begin
      exp_t e;
      wr_t  w;
      logic [15:0] d;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("mode", 32'(bus.o_mode), 32'(e.mode));
         chk("ctl_pulses", 32'({bus.o_rec_start, bus.o_rec_pause, bus.o_rec_stop,
                                bus.o_play_start, bus.o_play_pause, bus.o_play_stop}),
             32'(e.pulses));
         chk("play_valid", 32'(bus.o_play_valid), 32'(e.valid));
         chk("we_n", 32'(bus.o_sram_we_n), 32'(e.we_n));
         chk("oe_n", 32'(bus.o_sram_oe_n), 32'(e.oe_n));
         chk("overrun", 32'(bus.o_overrun), 32'(e.ovr));
         chk("end_addr", 32'(bus.o_end_addr), 32'(e.end_a));
         if (e.chk_rst) begin
            chk("rst_play_data", 32'(bus.o_play_data), 32'h0);
            chk("rst_sram_addr", 32'(bus.o_sram_addr), 32'h0);
         end
      end
      if (bus.o_sram_we_n === 1'b0 && we_prev === 1'b1) begin
         n_cmp++;
         if (wr_q.size() == 0) begin
            n_bad++;
            $display("FAIL write_event @%0t: actual=write to 0x%0h required=no write",
                     $time, bus.o_sram_addr);
         end else begin
            w = wr_q.pop_front();
            chk("write_addr", 32'(bus.o_sram_addr), 32'(w.a));
            chk("write_data", 32'(bus.o_sram_wdata), 32'(w.d));
         end
      end
      we_prev = bus.o_sram_we_n;
      if (bus.o_play_valid === 1'b1) begin
         n_cmp++;
         if (rd_q.size() == 0) begin
            n_bad++;
            $display("FAIL read_event @%0t: actual=play_valid required=none", $time);
         end else begin
            d = rd_q.pop_front();
            chk("play_data", 32'(bus.o_play_data), 32'(d));
         end
      end
   end

   // Driver request variables and reference model state
   logic        d_rst, d_krec, d_kplay, d_kpause, d_kstop, d_rv, d_pq;
   int          d_ra, d_pa;
   logic [15:0] d_rd;
   int cyc = 0;
   int m_mode = MI, m_end = 0, busy_until = -1;
   int we_lo = 0, we_hi = -1, oe_lo = 0, oe_hi = -1, pend_v = -1;
   logic m_ovr = 1'b0;
   logic [15:0] ref_mem [0:1023];
   int rec_ptr = 0;

   task automatic clear_req();
      d_rst = 0; d_krec = 0; d_kplay = 0; d_kpause = 0; d_kstop = 0;
      d_rv = 0; d_pq = 0; d_ra = 0; d_pa = 0; d_rd = 16'h0;
   endtask

   // One clock: drive requests, predict the next cycle, advance
   task automatic tick();
      int c, n_mode, n_end;
      logic n_ovr, acted;
      logic [5:0] pl;
      exp_t e;
      c = cyc;
      rst             = d_rst;
      bus.i_key_rec   = d_krec;
      bus.i_key_play  = d_kplay;
      bus.i_key_pause = d_kpause;
      bus.i_key_stop  = d_kstop;
      bus.i_rec_valid = d_rv;
      bus.i_rec_addr  = 20'(d_ra);
      bus.i_rec_data  = d_rd;
      bus.i_play_req  = d_pq;
      bus.i_play_addr = 20'(d_pa);
      n_mode = m_mode; n_end = m_end; n_ovr = m_ovr; pl = '0; acted = 0;
      if (d_rst) begin
         n_mode = MI; n_end = 0; n_ovr = 0;
         busy_until = c; we_hi = -1; oe_hi = -1;
         if (pend_v > c) begin
            pend_v = -1;
            void'(rd_q.pop_back());
         end
         for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0000;
      end else begin
         case (m_mode)
            MI: if (!d_kstop && !d_kpause) begin
                   if (d_krec) begin pl[5] = 1; n_end = 0; n_ovr = 0; n_mode = MR; end
                   else if (d_kplay && m_end != 0) begin pl[2] = 1; n_mode = MP; end
                end
            MR: if (d_kstop || m_end == C_MAX) begin pl[3] = 1; n_mode = MD; end
                else if (d_kpause) begin pl[4] = 1; n_mode = MRP; end
            MRP: if (d_kstop) begin pl[3] = 1; n_mode = MD; end
                 else if (d_kpause) begin pl[4] = 1; n_mode = MR; end
            MP: if (d_kstop) begin pl[0] = 1; n_mode = MD; acted = 1; end
                else if (d_kpause) begin pl[1] = 1; n_mode = MPP; acted = 1; end
            MPP: if (d_kstop) begin pl[0] = 1; n_mode = MD; acted = 1; end
                 else if (d_kpause) begin pl[1] = 1; n_mode = MP; acted = 1; end
            MD: if (c > busy_until) n_mode = MI;
            default: ;
         endcase
         if ((m_mode == MR || m_mode == MRP) && d_rv) begin
            if (c <= busy_until) n_ovr = 1;
            else begin
               wr_q.push_back({20'(d_ra), d_rd});
               ref_mem[d_ra] = d_rd;
               n_end = d_ra + 1;
               busy_until = c + C_ACC; we_lo = c + 1; we_hi = c + C_ACC;
            end
         end
         if ((m_mode == MP || m_mode == MPP) && d_pq) begin
            if (c <= busy_until) n_ovr = 1;
            else if (d_pa >= m_end) begin
               if (!acted) begin pl[0] = 1; n_mode = MI; end
            end else begin
               rd_q.push_back(ref_mem[d_pa]);
               pend_v = c + C_ACC + 1;
               busy_until = c + C_ACC; oe_lo = c + 1; oe_hi = c + C_ACC;
            end
         end
      end
      e.mode    = 3'(n_mode);
      e.pulses  = pl;
      e.valid   = (pend_v == c + 1);
      e.we_n    = !((c + 1 >= we_lo) && (c + 1 <= we_hi));
      e.oe_n    = !((c + 1 >= oe_lo) && (c + 1 <= oe_hi));
      e.ovr     = n_ovr;
      e.end_a   = 20'(n_end);
      e.chk_rst = d_rst;
      exp_q.push_back(e);
      m_mode = n_mode; m_end = n_end; m_ovr = n_ovr;
      @(posedge clk);
      cyc++;
      #1;
      clear_req();
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask
   task automatic wr(input int a, input logic [15:0] d);
      d_rv = 1; d_ra = a; d_rd = d; tick();
   endtask
   task automatic rd(input int a);
      d_pq = 1; d_pa = a; tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      clear_req();
      for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0000;
      d_rst = 1; tick();
      idle(2);
      // Record three words, then stop and drain
      d_krec = 1; tick(); idle(1);
      wr(0, 16'hA5A5); idle(7);
      wr(1, 16'h1234); idle(7);
      wr(2, 16'hFFFF); idle(7);
      d_kstop = 1; tick(); idle(4);
      // Playback: in-range fetch, then fetch at end_addr stops playback
      d_kplay = 1; tick(); idle(1);
      rd(1); idle(5);
      rd(3); idle(3);
      // Back-to-back writes: second dropped, overrun; new recording clears it
      d_krec = 1; tick(); idle(1);
      wr(0, 16'h1111); wr(1, 16'h2222); idle(4);
      d_kstop = 1; tick(); idle(3);
      d_krec = 1; tick(); idle(2);
      // Pause and stop together while a write is in flight
      wr(2, 16'h3333);
      d_kpause = 1; d_kstop = 1; tick(); idle(4);
      // Play with empty recording is ignored; capacity auto-stop
      d_rst = 1; tick();
      d_kplay = 1; tick(); idle(2);
      d_krec = 1; tick(); idle(1);
      for (int i = 0; i < C_MAX; i++) begin
         wr(i, 16'($urandom)); idle(2);
      end
      idle(4);
      // Reset in the middle of a read
      d_kplay = 1; tick(); idle(1);
      rd(5);
      d_rst = 1; tick(); idle(4);
      // Randomized traffic
      for (int i = 0; i < 2500; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 1) d_rst = 1;
         else if (r < 5) begin d_krec = 1; if (m_mode == MI) rec_ptr = 0; end
         else if (r < 9) d_kplay = 1;
         else if (r < 12) d_kpause = 1;
         else if (r < 14) d_kstop = 1;
         else if (r < 16) begin
            d_kpause = 1'($urandom_range(0, 1)); d_kstop = 1'($urandom_range(0, 1));
            d_krec = 1'($urandom_range(0, 1));   d_kplay = 1'($urandom_range(0, 1));
         end else if (r < 42) begin
            if (m_mode == MR || m_mode == MRP) begin
               d_rv = 1; d_ra = rec_ptr; d_rd = 16'($urandom);
               rec_ptr = (rec_ptr + 1) % 1024;
            end
         end else if (r < 67) begin
            if (m_mode == MP || m_mode == MPP) begin
               d_pq = 1;
               d_pa = int'($urandom_range(0, 32'(m_end + 1)));
               if (d_pa > 1023) d_pa = 1023;
            end
         end
         tick();
      end
      idle(10);
      @(negedge clk);
      #1;
      chk("leftover_writes", 32'(wr_q.size()), 32'h0);
      chk("leftover_reads", 32'(rd_q.size()), 32'h0);
      chk("leftover_cycles", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
